// File: rtl/hazard_sched.sv
// Hazard controller and FPU scheduler beside the ID/EX boundary: load-use stalls,
// a one-entry scoreboard for the iterative FP divide/sqrt, and writeback arbitration.
module hazard_sched #(
    parameter int FPU_LAT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [5:0] id_rs1,
    input  logic [5:0] id_rs2,
    input  logic [5:0] id_rs3,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_use_rs3,
    input  logic [5:0] id_rd,
    input  logic       id_reg_write,
    input  logic       id_long_op,
    input  logic [5:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       wb_pipe_valid,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       bubble_id_ex,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic       fpu_start,
    output logic       fpu_wb_grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] pend_rd_reg, pend_rd_next;
    logic [4:0] cnt_reg, cnt_next;

    // Integer x0 is hardwired and never creates a dependency; f0 is a real register.
    function automatic logic reg_match(input logic [5:0] r, input logic [5:0] p);
        return (r == p) && (r != 6'd0);
    endfunction

    logic [5:0] src [3];
    logic [2:0] src_use;
    logic [2:0] lu_hit;
    logic [2:0] sb_hit;

    assign src[0]  = id_rs1;
    assign src[1]  = id_rs2;
    assign src[2]  = id_rs3;
    assign src_use = {id_use_rs3, id_use_rs2, id_use_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign lu_hit[gi] = src_use[gi] & reg_match(src[gi], ex_rd);
            assign sb_hit[gi] = src_use[gi] & reg_match(src[gi], pend_rd_reg);
        end
    endgenerate

    logic in_flight;
    logic load_use;
    logic waw_hit;
    logic sb_hazard;
    logic struct_hazard;
    logic flush;
    logic stall;
    logic issue;
    logic grant;

    assign in_flight     = (state_reg != IDLE);
    assign load_use      = ex_mem_read & id_valid & (|lu_hit);
    assign waw_hit       = id_reg_write & reg_match(id_rd, pend_rd_reg);
    // The grant cycle still counts as in flight, so readers of pend_rd wait one more cycle.
    assign sb_hazard     = in_flight & id_valid & ((|sb_hit) | waw_hit);
    assign struct_hazard = in_flight & id_valid & id_long_op;
    assign flush         = ex_branch_taken;
    assign stall         = (load_use | sb_hazard | struct_hazard) & ~flush;
    assign issue         = id_valid & id_long_op & id_reg_write & ~in_flight & ~stall & ~flush;
    assign grant         = (state_reg == DONE) & ~wb_pipe_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pend_rd_reg <= 6'd0;
            cnt_reg     <= 5'd0;
        end else begin
            state_reg   <= state_next;
            pend_rd_reg <= pend_rd_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pend_rd_next = pend_rd_reg;
        cnt_next     = cnt_reg;
        stall_pc     = stall;
        stall_if_id  = stall;
        bubble_id_ex = stall;
        flush_if_id  = flush;
        flush_id_ex  = flush;
        fpu_start    = issue;
        fpu_wb_grant = 1'b0;
        busy         = in_flight;
        unique case (state_reg)
            IDLE: begin
                if (issue) begin
                    state_next   = BUSY;
                    pend_rd_next = id_rd;
                    cnt_next     = 5'(FPU_LAT);
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg <= 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Pipeline writeback wins; the FPU result waits here until the port is free.
                fpu_wb_grant = grant;
                if (grant) begin
                    state_next   = IDLE;
                    pend_rd_next = 6'd0;
                end
            end
            default: begin
                state_next   = IDLE;
                pend_rd_next = 6'd0;
                cnt_next     = 5'd0;
            end
        endcase
    end

endmodule
